miner_msa_stream: RTL and testbench

//   Streaming SHA-2 message schedule generator; successor to miner_core_msa, parametrised for SHA-256 or SHA-512.

---
 rtl/miner_msa_pkg.sv | 50 +++++
 rtl/miner_msa_sigma.sv | 29 ++
 rtl/miner_msa_stream.sv | 91 +++++++++
 tb/tb_miner_msa_stream.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/miner_msa_pkg.sv
// Shared types and SHA-2 sigma helpers for the streaming message schedule.
package miner_msa_pkg;

    typedef enum logic [0:0] {IDLE, EMIT} msa_state_t;

    // SHA-224/256 small-sigma rotate/shift amounts
    localparam int unsigned S0_ROR_A_32 = 7;
    localparam int unsigned S0_ROR_B_32 = 18;
    localparam int unsigned S0_SHR_32   = 3;
    localparam int unsigned S1_ROR_A_32 = 17;
    localparam int unsigned S1_ROR_B_32 = 19;
    localparam int unsigned S1_SHR_32   = 10;

    // SHA-384/512 small-sigma rotate/shift amounts
    localparam int unsigned S0_ROR_A_64 = 1;
    localparam int unsigned S0_ROR_B_64 = 8;
    localparam int unsigned S0_SHR_64   = 7;
    localparam int unsigned S1_ROR_A_64 = 19;
    localparam int unsigned S1_ROR_B_64 = 61;
    localparam int unsigned S1_SHR_64   = 6;

    // Rotate right within a w-bit word held in the low bits of a 64-bit carrier.
    function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n,
                                        input int unsigned w);
        logic [31:0] v;
        logic [63:0] r;
        v = x[31:0];
        if (w == 32) r = {32'h0, (v >> n) | (v << (32 - n))};
        else         r = (x >> n) | (x << (64 - n));
        return r;
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x, input int unsigned n,
                                        input int unsigned w);
        logic [31:0] v;
        v = x[31:0];
        return (w == 32) ? {32'h0, v >> n} : (x >> n);
    endfunction

    function automatic logic [63:0] sig0(input logic [63:0] x, input int unsigned w);
        if (w == 32) return ror(x, S0_ROR_A_32, w) ^ ror(x, S0_ROR_B_32, w) ^ shr(x, S0_SHR_32, w);
        else         return ror(x, S0_ROR_A_64, w) ^ ror(x, S0_ROR_B_64, w) ^ shr(x, S0_SHR_64, w);
    endfunction

    function automatic logic [63:0] sig1(input logic [63:0] x, input int unsigned w);
        if (w == 32) return ror(x, S1_ROR_A_32, w) ^ ror(x, S1_ROR_B_32, w) ^ shr(x, S1_SHR_32, w);
        else         return ror(x, S1_ROR_A_64, w) ^ ror(x, S1_ROR_B_64, w) ^ shr(x, S1_SHR_64, w);
    endfunction

endpackage

// File: rtl/miner_msa_sigma.sv
// Next schedule word: nxt = s1(w14) + w9 + s0(w1) + w0, carries beyond WORD_W dropped.
module miner_msa_sigma
    import miner_msa_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] nxt
);

    logic [63:0] e0, e1, e9, e14;

    // Zero-extend into the 64-bit carrier used by the package helpers, then add and truncate
    always_comb begin
        e0  = '0;
        e1  = '0;
        e9  = '0;
        e14 = '0;
        e0[WORD_W-1:0]  = w0;
        e1[WORD_W-1:0]  = w1;
        e9[WORD_W-1:0]  = w9;
        e14[WORD_W-1:0] = w14;
        nxt = WORD_W'(sig1(e14, WORD_W) + e9 + sig0(e1, WORD_W) + e0);
    end

endmodule

// File: rtl/miner_msa_stream.sv
// Streaming SHA-2 message schedule: rolling 16-word window, one W[t] per handshake.
module miner_msa_stream
    import miner_msa_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned IDX_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORD_W-1:0] chunk,
    input  logic                 abort,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w_data,
    output logic [IDX_W-1:0]     w_idx,
    output logic                 w_last,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    msa_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] win_q [16];
    logic [WORD_W-1:0] win_d [16];
    logic [WORD_W-1:0] nxt;
    logic              hs, accept;

    miner_msa_sigma #(
        .WORD_W (WORD_W)
    ) u_sigma (
        .w0  (win_q[0]),
        .w1  (win_q[1]),
        .w9  (win_q[9]),
        .w14 (win_q[14]),
        .nxt (nxt)
    );

    // Output decode; in_ready in EMIT lets the next chunk load on the final word handshake
    always_comb begin
        w_valid  = (state_q == EMIT);
        busy     = (state_q == EMIT);
        w_last   = w_valid && (idx_q == LAST_IDX);
        w_data   = win_q[0];
        w_idx    = idx_q;
        in_ready = !rst && ((state_q == IDLE) || (w_last && w_ready && !abort));
        hs       = w_valid && w_ready;
        accept   = in_valid && in_ready;
    end

    // Next state: abort beats accept beats word handshake
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;
        if (state_q == EMIT && abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (accept) begin
            for (int i = 0; i < 16; i++) win_d[i] = chunk[(15 - i) * WORD_W +: WORD_W];
            idx_d   = '0;
            state_d = EMIT;
        end else if (hs) begin
            for (int i = 0; i < 15; i++) win_d[i] = win_q[i + 1];
            win_d[15] = nxt;
            if (w_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // State, counter and window registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int i = 0; i < 16; i++) win_q[i] <= win_d[i];
        end
    end

endmodule

// File: tb/tb_miner_msa_stream.sv
// Directed bench for miner_msa_stream: SHA-256 instance plus a SHA-512 instance.
module tb_miner_msa_stream;

    logic         clk = 1'b0;
    // SHA-256 instance
    logic         rst_a, in_valid_a, in_ready_a, abort_a, w_valid_a, w_ready_a, w_last_a, busy_a;
    logic [511:0] chunk_a;
    logic [31:0]  w_data_a;
    logic [6:0]   w_idx_a;
    // SHA-512 instance
    logic         rst_b, in_valid_b, in_ready_b, abort_b, w_valid_b, w_ready_b, w_last_b, busy_b;
    logic [1023:0] chunk_b;
    logic [63:0]  w_data_b;
    logic [6:0]   w_idx_b;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] cw [16];
    logic [63:0] mw [80];
    logic [63:0] ms [80];
    logic [63:0] seen [80];

    always #5 clk = ~clk;

    miner_msa_stream #(.WORD_W(32), .ROUNDS(64), .IDX_W(7)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .chunk(chunk_a),
        .abort(abort_a), .w_valid(w_valid_a), .w_ready(w_ready_a), .w_data(w_data_a),
        .w_idx(w_idx_a), .w_last(w_last_a), .busy(busy_a)
    );

    miner_msa_stream #(.WORD_W(64), .ROUNDS(80), .IDX_W(7)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .chunk(chunk_b),
        .abort(abort_b), .w_valid(w_valid_b), .w_ready(w_ready_b), .w_data(w_data_b),
        .w_idx(w_idx_b), .w_last(w_last_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: textbook schedule recurrence over the whole W array
    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n, input int w);
        if (w == 32) return ((x >> n) | (x << (32 - n))) & 64'hFFFF_FFFF;
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] m_s0(input logic [63:0] x, input int w);
        if (w == 32) return m_ror(x, 7, w) ^ m_ror(x, 18, w) ^ (x >> 3);
        return m_ror(x, 1, w) ^ m_ror(x, 8, w) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] m_s1(input logic [63:0] x, input int w);
        if (w == 32) return m_ror(x, 17, w) ^ m_ror(x, 19, w) ^ (x >> 10);
        return m_ror(x, 19, w) ^ m_ror(x, 61, w) ^ (x >> 6);
    endfunction

    task automatic compute_model(input int w);
        logic [63:0] mask;
        mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        for (int t = 0; t < 16; t++) mw[t] = cw[t] & mask;
        for (int t = 16; t < 80; t++)
            mw[t] = (m_s1(mw[t-2], w) + mw[t-7] + m_s0(mw[t-15], w) + mw[t-16]) & mask;
    endtask

    task automatic pack_a();
        for (int i = 0; i < 16; i++) chunk_a[511 - 32*i -: 32] = cw[i][31:0];
    endtask

    task automatic random_chunk();
        for (int i = 0; i < 16; i++) cw[i] = {32'h0, $urandom()};
    endtask

    // Called just after a rising edge with dut_a idle
    task automatic accept_a();
        pack_a();
        in_valid_a = 1'b1;
        @(negedge clk);
        check("accept_in_ready", in_ready_a, 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    // Consume words from..to with w_ready high, checking against mw or the saved ms
    task automatic stream_a(input int from, input int to, input bit saved);
        logic [63:0] exp;
        w_ready_a = 1'b1;
        for (int t = from; t <= to; t++) begin
            @(negedge clk);
            exp = saved ? ms[t] : mw[t];
            seen[t] = {32'h0, w_data_a};
            check("w_valid", w_valid_a, 1);
            check("w_data", {32'h0, w_data_a}, exp);
            check("w_idx", {57'h0, w_idx_a}, t);
            check("w_last", w_last_a, (t == 63));
            if (in_valid_a && t == 62) check("b2b_in_ready_early", in_ready_a, 0);
            if (in_valid_a && t == 63) check("b2b_in_ready_w63", in_ready_a, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int t, cyc;
        rst_a = 1; in_valid_a = 0; abort_a = 0; w_ready_a = 0; chunk_a = '0;
        rst_b = 1; in_valid_b = 0; abort_b = 0; w_ready_b = 0; chunk_b = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", in_ready_a, 0);
        check("rst_w_valid", w_valid_a, 0);
        check("rst_w_idx", {57'h0, w_idx_a}, 0);
        check("rst_w_last", w_last_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_w_data", {32'h0, w_data_a}, 0);
        @(posedge clk); #1;
        rst_a = 0; rst_b = 0;

        // 1: SHA-256 "abc"
        for (int i = 0; i < 16; i++) cw[i] = '0;
        cw[0] = 64'h6162_6380; cw[15] = 64'h18;
        compute_model(32);
        accept_a();
        stream_a(0, 63, 0);
        check("abc_w16", seen[16], 64'h6162_6380);
        check("abc_w17", seen[17], 64'h000F_0000);
        @(negedge clk);
        check("abc_end_w_valid", w_valid_a, 0);
        check("abc_end_busy", busy_a, 0);
        check("abc_end_in_ready", in_ready_a, 1);
        @(posedge clk); #1;

        // 2: random stalls; expected word only advances on a handshake
        random_chunk();
        compute_model(32);
        accept_a();
        t = 0; cyc = 0;
        while (t < 64 && cyc < 2000) begin
            w_ready_a = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("stall_w_data", {32'h0, w_data_a}, mw[t]);
            check("stall_w_idx", {57'h0, w_idx_a}, t);
            if (w_ready_a) t++;
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_done", t, 64);
        w_ready_a = 1'b1;

        // 3: back-to-back chunks, second in_valid held high
        random_chunk();
        compute_model(32);
        for (int i = 0; i < 80; i++) ms[i] = mw[i];
        accept_a();
        random_chunk();
        compute_model(32);
        pack_a();
        in_valid_a = 1'b1;
        stream_a(0, 63, 1);
        in_valid_a = 1'b0;
        stream_a(0, 63, 0);

        // 4: abort at w_idx 20, with in_valid also high
        random_chunk();
        compute_model(32);
        accept_a();
        stream_a(0, 19, 0);
        abort_a = 1'b1; in_valid_a = 1'b1;
        @(negedge clk);
        check("abort_in_ready", in_ready_a, 0);
        @(posedge clk); #1;
        abort_a = 1'b0; in_valid_a = 1'b0;
        @(negedge clk);
        check("abort_w_valid", w_valid_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_w_idx", {57'h0, w_idx_a}, 0);
        @(posedge clk); #1;
        random_chunk();
        compute_model(32);
        accept_a();
        stream_a(0, 63, 0);

        // 5: reset at w_idx 40
        random_chunk();
        compute_model(32);
        accept_a();
        stream_a(0, 39, 0);
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready_a, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_w_valid", w_valid_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_w_idx", {57'h0, w_idx_a}, 0);
        check("rst_mid_w_last", w_last_a, 0);
        check("rst_mid_w_data", {32'h0, w_data_a}, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;

        // 6: SHA-512 "abc" on the 64-bit instance
        for (int i = 0; i < 16; i++) cw[i] = '0;
        cw[0] = 64'h6162_6380_0000_0000; cw[15] = 64'h18;
        compute_model(64);
        for (int i = 0; i < 16; i++) chunk_b[1023 - 64*i -: 64] = cw[i];
        in_valid_b = 1'b1;
        @(negedge clk);
        check("b_in_ready", in_ready_b, 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        w_ready_b = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            check("b_w_data", w_data_b, mw[k]);
            check("b_w_idx", {57'h0, w_idx_b}, k);
            check("b_w_last", w_last_b, (k == 79));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("b_end_busy", busy_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
